// File: rtl/mmio_fabric_pkg.sv
// Shared definitions for the memory-map fabric: state/class enums, default
// window constants and named peripheral slots.
package mmio_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } fabric_state_t;

  typedef enum logic [1:0] {
    DMEM,
    SLOT,
    UNMAPPED
  } access_class_t;

  localparam logic [15:0] MMIO_BASE = 16'hC000;
  localparam logic [15:0] ERR_DATA  = 16'hDEAD;

  localparam int SLOT_LED   = 0;
  localparam int SLOT_SPART = 1;
  localparam int SLOT_BMP   = 2;

  // A single slot still needs one index bit so the window compare stays well formed.
  function automatic int slot_bits(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

// File: rtl/mmio_fabric_decode.sv
// Combinational address decode: word address -> access class, slot index and
// register offset inside the slot.
module mmio_decode
  import mmio_fabric_pkg::*;
#(
  parameter int          DMEM_DEPTH = 14,
  parameter int          NUM_SLOTS  = 4,
  parameter int          SLOT_SHIFT = 2,
  parameter int          SLOT_BITS  = 2,
  parameter logic [15:0] WIN_BASE   = 16'hC000
) (
  input  logic [15:0]           addr,
  output access_class_t         cls,
  output logic [SLOT_BITS-1:0]  slot,
  output logic [SLOT_SHIFT-1:0] offset
);

  localparam int WIN_LSB = SLOT_SHIFT + SLOT_BITS;
  localparam logic [SLOT_BITS:0] NSLOT = NUM_SLOTS[SLOT_BITS:0];

  logic in_dmem;
  logic in_window;

  assign slot      = addr[WIN_LSB-1:SLOT_SHIFT];
  assign offset    = addr[SLOT_SHIFT-1:0];
  assign in_dmem   = (addr[15:DMEM_DEPTH] == '0);
  assign in_window = (addr[15:WIN_LSB] == WIN_BASE[15:WIN_LSB]);

  always_comb begin
    cls = UNMAPPED;
    if (in_dmem) begin
      cls = DMEM;
    end else if (in_window && ({1'b0, slot} < NSLOT)) begin
      cls = SLOT;
    end
  end

endmodule

// File: rtl/mmio_fabric.sv
// Request/ready interconnect from the processor data port to DMEM and the
// peripheral slots, with slave timeout and a sticky bus-error log.
//
// state | meaning
// IDLE  | waiting for req_i; decodes and registers the access
// WAIT  | DMEM strobe cycle, or slave request held until ack/timeout
// RESP  | one-cycle ready_o with read data, then back to IDLE
module mmio_fabric #(
  parameter int          DMEM_DEPTH     = 14,
  parameter int          NUM_SLOTS      = 4,
  parameter int          SLOT_SHIFT     = 2,
  parameter logic [15:0] MMIO_BASE      = mmio_fabric_pkg::MMIO_BASE,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [15:0] ERR_DATA       = mmio_fabric_pkg::ERR_DATA
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [15:0]             addr_i,
  input  logic [15:0]             wdata_i,
  output logic [15:0]             rdata_o,
  output logic                    ready_o,
  output logic                    dmem_en_o,
  output logic                    dmem_we_o,
  output logic [DMEM_DEPTH-1:0]   dmem_addr_o,
  output logic [15:0]             dmem_wdata_o,
  input  logic [15:0]             dmem_rdata_i,
  output logic [NUM_SLOTS-1:0]    slv_req_o,
  output logic                    slv_we_o,
  output logic [SLOT_SHIFT-1:0]   slv_addr_o,
  output logic [15:0]             slv_wdata_o,
  input  logic [16*NUM_SLOTS-1:0] slv_rdata_i,
  input  logic [NUM_SLOTS-1:0]    slv_ack_i,
  output logic                    err_o,
  output logic [15:0]             err_addr_o,
  input  logic                    err_clr_i
);

  import mmio_fabric_pkg::*;

  localparam int SLOT_BITS = slot_bits(NUM_SLOTS);
  localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);

  fabric_state_t state, state_nxt;

  access_class_t         dec_cls;
  logic [SLOT_BITS-1:0]  dec_slot;
  logic [SLOT_SHIFT-1:0] dec_off;

  access_class_t         cls_q;
  logic [SLOT_SHIFT-1:0] off_q;
  logic [15:0]           addr_q;
  logic [15:0]           wdata_q;
  logic [15:0]           rdata_q;
  logic                  we_q;
  logic [NUM_SLOTS-1:0]  slv_req_q;
  logic [NUM_SLOTS-1:0]  dec_onehot;
  logic [CNT_W-1:0]      wait_cnt;

  logic        accept;
  logic        ack_hit;
  logic        timeout_hit;
  logic [15:0] ack_data;
  logic        fault;
  logic [15:0] fault_addr;
  logic        err_q;
  logic [15:0] err_addr_q;

  mmio_decode #(
    .DMEM_DEPTH (DMEM_DEPTH),
    .NUM_SLOTS  (NUM_SLOTS),
    .SLOT_SHIFT (SLOT_SHIFT),
    .SLOT_BITS  (SLOT_BITS),
    .WIN_BASE   (MMIO_BASE)
  ) u_decode (
    .addr   (addr_i),
    .cls    (dec_cls),
    .slot   (dec_slot),
    .offset (dec_off)
  );

  always_comb begin
    dec_onehot = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      dec_onehot[k] = (dec_slot == SLOT_BITS'(k));
    end
  end

  always_comb begin
    ack_data = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      ack_data = ack_data | (slv_rdata_i[16*k +: 16] & {16{slv_req_q[k]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    ready_o     = 1'b0;
    rdata_o     = '0;
    dmem_en_o   = 1'b0;
    dmem_we_o   = 1'b0;
    slv_we_o    = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          accept    = 1'b1;
          state_nxt = (dec_cls == UNMAPPED) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cls_q == DMEM) begin
          dmem_en_o = 1'b1;
          dmem_we_o = we_q;
          state_nxt = RESP;
        end else begin
          slv_we_o = we_q;
          // Ack wins over a timeout landing in the same cycle.
          ack_hit     = |(slv_ack_i & slv_req_q);
          timeout_hit = !ack_hit && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
          if (ack_hit || timeout_hit) begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        ready_o   = 1'b1;
        state_nxt = IDLE;
        if (!we_q) begin
          rdata_o = (cls_q == DMEM) ? dmem_rdata_i : rdata_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q     <= DMEM;
      off_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      slv_req_q <= '0;
      wait_cnt  <= '0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (accept) begin
        cls_q     <= dec_cls;
        off_q     <= dec_off;
        addr_q    <= addr_i;
        wdata_q   <= wdata_i;
        we_q      <= we_i;
        rdata_q   <= '0;
        slv_req_q <= (dec_cls == SLOT) ? dec_onehot : '0;
      end else if (ack_hit || timeout_hit) begin
        slv_req_q <= '0;
        if (!we_q) begin
          rdata_q <= ack_hit ? ack_data : ERR_DATA;
        end
      end
    end
  end

  assign fault      = (accept && (dec_cls == UNMAPPED)) || timeout_hit;
  assign fault_addr = accept ? addr_i : addr_q;

  // A fault beats a simultaneous clear, and then records the new address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (fault) begin
      err_q <= 1'b1;
      if (!err_q || err_clr_i) begin
        err_addr_q <= fault_addr;
      end
    end else if (err_clr_i) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end
  end

  assign slv_req_o    = slv_req_q;
  assign slv_addr_o   = off_q;
  assign slv_wdata_o  = wdata_q;
  assign dmem_addr_o  = addr_q[DMEM_DEPTH-1:0];
  assign dmem_wdata_o = wdata_q;
  assign err_o        = err_q;
  assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_mmio_fabric.sv
// Scoreboarded bench for mmio_fabric: directed accesses push expected read
// data, a negedge monitor pops and compares on every ready_o.
module tb_mmio_fabric;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [15:0] addr_i = '0;
  logic [15:0] wdata_i = '0;
  logic [15:0] rdata_o;
  logic        ready_o;
  logic        dmem_en_o;
  logic        dmem_we_o;
  logic [13:0] dmem_addr_o;
  logic [15:0] dmem_wdata_o;
  logic [15:0] dmem_rdata_i;
  logic [3:0]  slv_req_o;
  logic        slv_we_o;
  logic [1:0]  slv_addr_o;
  logic [15:0] slv_wdata_o;
  logic [63:0] slv_rdata_i;
  logic [3:0]  slv_ack_i;
  logic        err_o;
  logic [15:0] err_addr_o;
  logic        err_clr_i = 1'b0;

  always #5 clk = ~clk;

  mmio_fabric dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rdata_o      (rdata_o),
    .ready_o      (ready_o),
    .dmem_en_o    (dmem_en_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_rdata_i (dmem_rdata_i),
    .slv_req_o    (slv_req_o),
    .slv_we_o     (slv_we_o),
    .slv_addr_o   (slv_addr_o),
    .slv_wdata_o  (slv_wdata_o),
    .slv_rdata_i  (slv_rdata_i),
    .slv_ack_i    (slv_ack_i),
    .err_o        (err_o),
    .err_addr_o   (err_addr_o),
    .err_clr_i    (err_clr_i)
  );

  // Synchronous RAM model, read-first, one cycle latency.
  logic [15:0] mem [0:16383];
  logic [15:0] dmem_rd = '0;
  always @(posedge clk) begin
    if (dmem_en_o) begin
      if (dmem_we_o) mem[dmem_addr_o] <= dmem_wdata_o;
      dmem_rd <= mem[dmem_addr_o];
    end
  end
  assign dmem_rdata_i = dmem_rd;

  // Slave model: slot k acks in the ack_after[k]-th request cycle (0 = never).
  int          ack_after [4];
  logic [15:0] slv_data  [4];
  logic [3:0]  spur_ack = '0;
  int          rq_cnt    [4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) rq_cnt[k] <= slv_req_o[k] ? rq_cnt[k] + 1 : 0;
  end

  always_comb begin
    slv_ack_i   = '0;
    slv_rdata_i = '0;
    for (int k = 0; k < 4; k++) begin
      slv_ack_i[k] = spur_ack[k] |
                     (slv_req_o[k] && (ack_after[k] != 0) && (rq_cnt[k] == ack_after[k] - 1));
      slv_rdata_i[16*k +: 16] = slv_data[k];
    end
  end

  int          nchk = 0;
  int          nerr = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ready_o) begin
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_ready actual=%0h required=none", rdata_o);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rdata", {16'h0, rdata_o}, {16'h0, mon_exp});
      end
    end
  end

  // Drives one access (req already aligned to a negedge) and checks latency
  // and the strobes seen on the way; read data goes through the scoreboard.
  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rd, input int exp_lat,
                        input logic [3:0] exp_mask, input int exp_strobes, input logic clr);
    int n = 0;
    int en_cnt = 0;
    int sreq_cnt = 0;
    int bad = 0;
    bit done = 0;
    exp_q.push_back(exp_rd);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; err_clr_i = clr;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      err_clr_i = 1'b0;
      if (dmem_en_o) begin
        en_cnt++;
        if (n != exp_lat - 1 || dmem_addr_o != addr[13:0] || dmem_we_o != we ||
            (we && dmem_wdata_o != wdata)) bad++;
      end
      if (slv_req_o != 4'b0) begin
        sreq_cnt++;
        if (slv_req_o != exp_mask || slv_addr_o != addr[1:0] || slv_we_o != we ||
            (we && slv_wdata_o != wdata)) bad++;
      end
      if (ready_o) done = 1;
    end
    req_i = 1'b0; we_i = 1'b0;
    chk($sformatf("ready_seen_%h", addr), {31'h0, done}, 32'd1);
    chk($sformatf("latency_%h", addr), n, exp_lat);
    chk($sformatf("dmem_strobes_%h", addr), en_cnt, (exp_mask == 4'b0) ? exp_strobes : 0);
    chk($sformatf("slv_strobes_%h", addr), sreq_cnt, (exp_mask == 4'b0) ? 0 : exp_strobes);
    chk($sformatf("bus_fields_%h", addr), bad, 0);
  endtask

  task automatic chk_err(input string nm, input logic e, input logic [15:0] a);
    chk({nm, "_err"}, {31'h0, err_o}, {31'h0, e});
    chk({nm, "_err_addr"}, {16'h0, err_addr_o}, {16'h0, a});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 4; k++) ack_after[k] = 0;
    slv_data[0] = 16'h1111; slv_data[1] = 16'h00A5;
    slv_data[2] = 16'h2222; slv_data[3] = 16'h3333;

    repeat (3) @(negedge clk);
    chk("reset_strobes", {26'h0, ready_o, dmem_en_o, slv_req_o}, 32'h0);
    chk("reset_rdata", {16'h0, rdata_o}, 32'h0);
    chk_err("reset", 1'b0, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // DMEM write, read, back-to-back read, top-of-DMEM address.
    access(1'b1, 16'h0010, 16'h1234, 16'h0000, 2, 4'b0, 1, 1'b0);
    @(negedge clk);
    access(1'b0, 16'h0010, 16'h0000, 16'h1234, 2, 4'b0, 1, 1'b0);
    access(1'b0, 16'h0010, 16'h0000, 16'h1234, 3, 4'b0, 1, 1'b0);
    @(negedge clk);
    access(1'b1, 16'h3FFF, 16'hBEEF, 16'h0000, 2, 4'b0, 1, 1'b0);
    @(negedge clk);
    access(1'b0, 16'h3FFF, 16'h0000, 16'hBEEF, 2, 4'b0, 1, 1'b0);
    chk_err("dmem", 1'b0, 16'h0000);

    // Slot 1 read acked in its third request cycle.
    ack_after[1] = 3;
    @(negedge clk);
    access(1'b0, 16'hC005, 16'h0000, 16'h00A5, 4, 4'b0010, 3, 1'b0);
    chk_err("slot1", 1'b0, 16'h0000);

    // Acks on unselected slots 0 and 3 must not end a slot-1 access early.
    ack_after[1] = 2; slv_data[1] = 16'h7E57; spur_ack = 4'b1001;
    @(negedge clk);
    access(1'b0, 16'hC007, 16'h0000, 16'h7E57, 3, 4'b0010, 2, 1'b0);
    spur_ack = 4'b0000;

    // Slot 1 write acked immediately.
    ack_after[1] = 1;
    @(negedge clk);
    access(1'b1, 16'hC006, 16'h55AA, 16'h0000, 2, 4'b0010, 1, 1'b0);

    // Ack in the 16th wait cycle coincides with the timeout: success.
    ack_after[1] = 16; slv_data[1] = 16'h5A5A;
    @(negedge clk);
    access(1'b0, 16'hC004, 16'h0000, 16'h5A5A, 17, 4'b0010, 16, 1'b0);
    chk_err("ack_at_limit", 1'b0, 16'h0000);

    // Slot 2 write never acked: timeout, error logged.
    @(negedge clk);
    access(1'b1, 16'hC00A, 16'h0042, 16'h0000, 17, 4'b0100, 16, 1'b0);
    chk_err("timeout_wr", 1'b1, 16'hC00A);

    // Slot 3 read timeout returns ERR_DATA; first fault address kept.
    @(negedge clk);
    access(1'b0, 16'hC00C, 16'h0000, 16'hDEAD, 17, 4'b1000, 16, 1'b0);
    chk_err("timeout_rd", 1'b1, 16'hC00A);

    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    chk_err("clear1", 1'b0, 16'h0000);

    // Unmapped accesses answer in cycle 1 with zero data.
    @(negedge clk);
    access(1'b0, 16'h8000, 16'h0000, 16'h0000, 1, 4'b0, 0, 1'b0);
    chk_err("unmapped1", 1'b1, 16'h8000);
    @(negedge clk);
    access(1'b0, 16'hC010, 16'h0000, 16'h0000, 1, 4'b0, 0, 1'b0);
    chk_err("unmapped2", 1'b1, 16'h8000);
    @(negedge clk);
    access(1'b0, 16'h4000, 16'h0000, 16'h0000, 1, 4'b0, 0, 1'b0);
    chk_err("unmapped3", 1'b1, 16'h8000);

    // Clear and a new fault in the same cycle: the fault wins.
    @(negedge clk);
    access(1'b0, 16'hF000, 16'h0000, 16'h0000, 1, 4'b0, 0, 1'b1);
    chk_err("clr_vs_fault", 1'b1, 16'hF000);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    chk_err("clear2", 1'b0, 16'h0000);

    // Reset while slot 0 is waiting: request drops, no ready, next access normal.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 16'hC000;
    repeat (3) @(negedge clk);
    chk("wait_slot0_req", {28'h0, slv_req_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {28'h0, slv_req_o}, 32'h0);
    chk("rst_mid_ready", {31'h0, ready_o}, 32'h0);
    req_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_ready", {31'h0, ready_o}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    ack_after[0] = 1;
    access(1'b0, 16'hC002, 16'h0000, 16'h1111, 2, 4'b0001, 1, 1'b0);
    chk_err("after_rst", 1'b0, 16'h0000);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mmio_fabric.md
Name: mmio_fabric

Overview:
- Parametrised memory-map interconnect between the processor data port and physical data memory plus NUM_SLOTS peripheral windows (LED/SW, SPART, BMP, spare).
- Replaces the purely combinational address decode with a request/ready handshake.
- Peripherals with variable latency can stall the processor.
- Unmapped or hung accesses terminate with a bus-error response instead of silently returning 0.

Parameters:
- DMEM_DEPTH, 14, number of low address bits covering physical DMEM; DMEM region is addr[15:DMEM_DEPTH]==0.
- NUM_SLOTS, 4, number of peripheral slots (≥1).
- SLOT_SHIFT, 2, log2 of registers per slot; slave offset = addr[SLOT_SHIFT-1:0].
- MMIO_BASE, 16'hC000, base of peripheral window; must be aligned to 2^(SLOT_SHIFT+SLOT_BITS).
- TIMEOUT_CYCLES, 16, WAIT cycles allowed before a slave access is aborted (≥1).
- ERR_DATA, 16'hDEAD, read data returned on timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_i  in  1  processor access request (re|we); held stable until ready_o
- we_i  in  1  1=write, 0=read
- addr_i  in  16  byte-less word address
- wdata_i  in  16  write data
- rdata_o  out  16  read data, valid when ready_o
- ready_o  out  1  one-cycle completion pulse
- dmem_en_o  out  1  DMEM access strobe
- dmem_we_o  out  1  DMEM write enable
- dmem_addr_o  out  DMEM_DEPTH  DMEM address
- dmem_wdata_o  out  16  DMEM write data
- dmem_rdata_i  in  16  DMEM read data (synchronous RAM, 1-cycle latency)
- slv_req_o  out  NUM_SLOTS  one-hot slave request, held until ack
- slv_we_o  out  1  shared write flag
- slv_addr_o  out  SLOT_SHIFT  shared register offset
- slv_wdata_o  out  16  shared write data
- slv_rdata_i  in  16*NUM_SLOTS  packed slave read data; slot k at [16k+15:16k]
- slv_ack_i  in  NUM_SLOTS  slave completion, sampled only when the matching slv_req_o is high
- err_o  out  1  sticky bus-error flag
- err_addr_o  out  16  address of first faulting access since last clear
- err_clr_i  in  1  clears err_o and err_addr_o

Behaviour:
- localparam SLOT_BITS = max(1, clog2(NUM_SLOTS)).
- FSM states: IDLE, WAIT, RESP.
- Reset (async): state=IDLE, all outputs 0, timeout counter 0. A reset mid-access abandons the access; no ready_o.
- IDLE, req_i=1: register addr/we/wdata and decode class:
  - DMEM if addr[15:DMEM_DEPTH]==0.
  - SLOT k if addr[15:SLOT_SHIFT+SLOT_BITS]==MMIO_BASE upper bits and slot index k<NUM_SLOTS.
  - Otherwise UNMAPPED.
- DMEM and SLOT go to WAIT. UNMAPPED goes to RESP with rdata=0 and the error logged.
- WAIT, DMEM:
  - dmem_en_o=1 for exactly one cycle; dmem_we_o=we.
  - Next state RESP; rdata_o is driven from dmem_rdata_i during RESP.
  - Total latency: request cycle 0, ready_o in cycle 2.
- WAIT, SLOT k:
  - slv_req_o[k]=1 (registered), shared address/data buses stable.
  - Counter increments each WAIT cycle.
  - slv_ack_i[k]=1: capture slv_rdata_i slice k into the read register, drop request, go to RESP. Minimum latency: ready_o in cycle 2 when ack arrives in cycle 1.
  - Counter reaches TIMEOUT_CYCLES without ack: drop request, rdata=ERR_DATA, log error, go to RESP.
- RESP: ready_o=1 for one cycle, then IDLE.
  - A new req_i is accepted no earlier than the cycle after RESP, giving back-to-back accesses every 3 cycles.
  - For writes, rdata_o=0.
- Ack rules:
  - Ack on a non-selected slot is ignored.
  - Ack on the same cycle the timeout is reached counts as success, since ack has priority.
- Error logging:
  - err_o sets on UNMAPPED or timeout.
  - err_addr_o captures the address only if err_o was previously 0, so the first fault wins.
  - err_clr_i in the same cycle as a new fault: the fault wins; err_o stays 1 and err_addr_o takes the new address.
- rdata_o and all slave/DMEM strobes are 0 outside their stated states.
- req_i dropped during WAIT is a protocol violation; the fabric completes the access regardless.

Decomposition:
- Shared package MiniLab_defs gains:
  - fabric_state_t enum (IDLE/WAIT/RESP).
  - access_class_t enum (DMEM/SLOT/UNMAPPED).
  - MMIO_BASE and ERR_DATA constants.
  - Slot index constants: SLOT_LED=0, SLOT_SPART=1, SLOT_BMP=2.
- One natural sub-module, mmio_decode: purely combinational address → {class, slot index, offset}. It is instantiated once and unit-testable in isolation.

Test Plan:
- DMEM: write 16'h1234 to 16'h0010, then read 16'h0010 → dmem_en_o pulses in cycle 1 of each access; read ready_o in cycle 2 with rdata_o=16'h1234.
- Slot 1 read 16'hC005, slave acks after 3 cycles with 16'h00A5 → slv_req_o=4'b0010 for 3 cycles, slv_addr_o=1; ready_o follows one cycle after ack; rdata_o=16'h00A5; err_o=0.
- Slot 2 write 16'hC00A, wdata 16'h0042, no ack → slv_req_o[2] held 16 cycles then drops; ready_o=1; err_o=1; err_addr_o=16'hC00A. A read timeout returns rdata_o=16'hDEAD.
- Unmapped read 16'h8000, then unmapped 16'hC010 → both ready_o in cycle 1 with rdata_o=0; err_addr_o stays 16'h8000; err_clr_i then clears err_o to 0.
- Ack on cycle 16 (coincides with timeout) → success; rdata_o = slave data; err_o unchanged.
- Assert rst_n=0 during WAIT on slot 0 → slv_req_o=0 immediately; no ready_o; state IDLE; next access completes normally.
